rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_arb_pkg.sv | 24 ++
 rtl/onehotmux.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_mux_arbiter.sv | 108 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types for the round-robin mux arbiter.
// Holds requester count, FSM state enum, pointer type and a one-hot encoder.
package rr_arb_pkg;

   localparam int NUM_REQ = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef logic [2:0] ptr_t;

   // Index of the set bit of a one-hot (or zero) vector; 0 when empty.
   function automatic ptr_t onehot2idx(input logic [NUM_REQ-1:0] oh);
      ptr_t idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) idx = idx | ptr_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehotmux.sv
// Generic AND-OR one-hot multiplexer.
// Ports: sel (one-hot or 0), data (N words), out (selected word or 0).
module onehotmux #(
   parameter int N     = 8,
   parameter int WIDTH = 32
) (
   input  logic [N-1:0]            sel,
   input  logic [N-1:0][WIDTH-1:0] data,
   output logic [WIDTH-1:0]        out
);

   always_comb begin
      out = '0;
      for (int i = 0; i < N; i++) begin
         out = out | (data[i] & {WIDTH{sel[i]}});
      end
   end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit from ptr+1 upward, mod 8.
// Ports: req (requests), ptr (last grant), gnt (one-hot grant or 0).
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  ptr_t               ptr,
   output logic [NUM_REQ-1:0] gnt
);

   ptr_t w_idx;
   logic w_found;

   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_idx   = '0;
      // k = 8 wraps to ptr itself, so the last grantee is lowest priority
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = ptr + ptr_t'(k);
         if (!w_found && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 8:1 arbiter with a one-word registered output stage.
// Ports: clk, reset (sync, active-high), req/in0..in7 requesters, ack pulse,
//        out_valid/out_ready/out_data handshake, sel grant of held word,
//        stall_count (live only with RR_ARB_STALL_CNT_EN defined, else 0).
module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQ-1:0]  req,
   input  logic [WIDTH-1:0]    in0,
   input  logic [WIDTH-1:0]    in1,
   input  logic [WIDTH-1:0]    in2,
   input  logic [WIDTH-1:0]    in3,
   input  logic [WIDTH-1:0]    in4,
   input  logic [WIDTH-1:0]    in5,
   input  logic [WIDTH-1:0]    in6,
   input  logic [WIDTH-1:0]    in7,
   output logic [NUM_REQ-1:0]  ack,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [NUM_REQ-1:0]  sel,
   output logic [15:0]         stall_count
);

   state_t                     r_state;
   ptr_t                       r_ptr;
   logic [WIDTH-1:0]           r_data;
   logic [NUM_REQ-1:0]         r_sel;

   logic [NUM_REQ-1:0]         w_gnt;
   logic [NUM_REQ-1:0][WIDTH-1:0] w_in;
   logic [WIDTH-1:0]           w_mux;
   logic                       w_can_cap;
   logic                       w_take;

   assign w_in[0] = in0;
   assign w_in[1] = in1;
   assign w_in[2] = in2;
   assign w_in[3] = in3;
   assign w_in[4] = in4;
   assign w_in[5] = in5;
   assign w_in[6] = in6;
   assign w_in[7] = in7;

   rr_pick u_pick (
      .req (req),
      .ptr (r_ptr),
      .gnt (w_gnt)
   );

   onehotmux #(
      .N     (NUM_REQ),
      .WIDTH (WIDTH)
   ) u_mux (
      .sel  (w_gnt),
      .data (w_in),
      .out  (w_mux)
   );

   assign w_can_cap = (r_state == EMPTY) || out_ready;
   // Capture only outside reset; ack mirrors the capture in the same cycle
   assign w_take    = w_can_cap && !reset && (|req);
   assign ack       = w_take ? w_gnt : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_ptr   <= ptr_t'(NUM_REQ - 1);
         r_data  <= '0;
         r_sel   <= '0;
      end else if (w_can_cap) begin
         if (|req) begin
            r_state <= FULL;
            r_ptr   <= onehot2idx(w_gnt);
            r_data  <= w_mux;
            r_sel   <= w_gnt;
         end else begin
            r_state <= EMPTY;
            r_sel   <= '0;
         end
      end
   end

   assign out_valid = (r_state == FULL);
   assign out_data  = r_data;
   assign sel       = r_sel;

`ifdef RR_ARB_STALL_CNT_EN
   logic [15:0] r_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall <= '0;
      end else if (out_valid && !out_ready && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   assign stall_count = r_stall;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter.
// Inputs change on negedge; outputs are compared 1ns later.
module tb_rr_mux_arbiter;

   logic        clk;
   logic        reset;
   logic [7:0]  req;
   logic [31:0] d [8];
   logic [7:0]  ack;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  sel;
   logic [15:0] stall_count;

   int checks;
   int failures;

`ifdef RR_ARB_STALL_CNT_EN
   localparam logic [15:0] STALL5   = 16'd5;
   localparam logic [15:0] STALLSAT = 16'hFFFF;
`else
   localparam logic [15:0] STALL5   = 16'd0;
   localparam logic [15:0] STALLSAT = 16'd0;
`endif

   rr_mux_arbiter #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .in0         (d[0]),
      .in1         (d[1]),
      .in2         (d[2]),
      .in3         (d[3]),
      .in4         (d[4]),
      .in5         (d[5]),
      .in6         (d[6]),
      .in7         (d[7]),
      .ack         (ack),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .sel         (sel),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req       = 8'h00;
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      d[0] = 32'h0000_00A5;
      for (int i = 1; i < 8; i++) d[i] = 32'h1111_1111 * i;
      reset     = 1'b1;
      req       = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      tick();

      // reset state, and no capture while reset is high
      req = 8'hFF;
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_sel", sel, 8'h00);
      chk("rst_data", out_data, 32'h0);
      chk("rst_stall", stall_count, 16'h0);
      chk("rst_ack", ack, 8'h00);
      tick();
      reset = 1'b0;
      req   = 8'h00;
      #1;
      chk("rst_nocap", out_valid, 1'b0);

      // single capture from requester 0
      req       = 8'h01;
      out_ready = 1'b1;
      #1;
      chk("s_ack", ack, 8'h01);
      tick();
      req = 8'h00;
      #1;
      chk("s_valid", out_valid, 1'b1);
      chk("s_data", out_data, 32'hA5);
      chk("s_sel", sel, 8'h01);
      chk("s_ack0", ack, 8'h00);
      tick();
      #1;
      chk("s_drain", out_valid, 1'b0);
      chk("s_sel0", sel, 8'h00);

      // full-rate round robin
      do_reset();
      req       = 8'hFF;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("rr_ack%0d", i), ack, 8'h01 << (i % 8));
         if (i > 0) begin
            chk($sformatf("rr_v%0d", i), out_valid, 1'b1);
            chk($sformatf("rr_d%0d", i), out_data, d[(i - 1) % 8]);
         end
         tick();
      end
      req = 8'h00;

      // backpressure hold after capture from 3
      do_reset();
      req       = 8'h08;
      out_ready = 1'b1;
      #1;
      chk("bp_ack3", ack, 8'h08);
      tick();
      req       = 8'hFF;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp_ack%0d", k), ack, 8'h00);
         chk($sformatf("bp_d%0d", k), out_data, d[3]);
         chk($sformatf("bp_sel%0d", k), sel, 8'h08);
         tick();
      end
      #1;
      chk("bp_stall", stall_count, STALL5);

      // reset while full and stalled
      req   = 8'h10;
      reset = 1'b1;
      #1;
      chk("rf_ack", ack, 8'h00);
      tick();
      reset = 1'b0;
      #1;
      chk("rf_valid", out_valid, 1'b0);
      chk("rf_sel", sel, 8'h00);
      chk("rf_stall", stall_count, 16'h0);
      chk("rf_ack4", ack, 8'h10);
      tick();
      req = 8'h00;
      #1;
      chk("rf_d4", out_data, d[4]);
      chk("rf_sel4", sel, 8'h10);

      // wrap-around from ptr=5
      do_reset();
      req       = 8'h20;
      out_ready = 1'b1;
      #1;
      chk("wr_ack5", ack, 8'h20);
      tick();
      req = 8'h21;
      #1;
      chk("wr_ack0", ack, 8'h01);
      tick();
      #1;
      chk("wr_d0", out_data, d[0]);
      chk("wr_back5", ack, 8'h20);
      tick();
      req = 8'h00;
      #1;
      chk("wr_d5", out_data, d[5]);

      // stall counter saturation
      do_reset();
      req       = 8'h04;
      out_ready = 1'b1;
      tick();
      req       = 8'h00;
      out_ready = 1'b0;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      #1;
      chk("sat_val", stall_count, STALLSAT);
      chk("sat_valid", out_valid, 1'b1);
      tick();
      #1;
      chk("sat_hold", stall_count, STALLSAT);
      chk("sat_data", out_data, d[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
